// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and receiver FSM state encoding.
// Ports: none (package).
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4,
        BREAK   = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle towards the host-side byte consumer.
// Ports: o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Active.
interface uart_rx_if;
    import uart_pkg::*;

    logic                      o_Rx_DV;
    logic [UART_DATA_BITS-1:0] o_Rx_Byte;
    logic                      o_Rx_Frame_Err;
    logic                      o_Rx_Active;

    modport master (
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_Rx_Frame_Err,
        output o_Rx_Active
    );

    modport slave (
        input o_Rx_DV,
        input o_Rx_Byte,
        input o_Rx_Frame_Err,
        input o_Rx_Active
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial pin, resets to idle-high.
// Ports: i_Clock, i_Rst_n (sync, active-low), i_Async in, o_Sync out.
module uart_rx_sync (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Async,
    output logic o_Sync
);

    logic meta;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            meta   <= 1'b1;
            o_Sync <= 1'b1;
        end else begin
            meta   <= i_Async;
            o_Sync <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, false-start rejection, framing errors.
// Ports: i_Clock, i_Rst_n (sync, active-low), i_Rx_Serial, rx_if (outputs).
module uart_rx
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 87,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    uart_rx_if.master  rx_if
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      rx_s;
    uart_state_e               state;
    logic [CNT_W-1:0]          cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [UART_DATA_BITS-1:0] rx_byte;
    logic                      rx_dv;
    logic                      rx_err;
    logic                      rx_active;

    uart_rx_sync u_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_Async (i_Rx_Serial),
        .o_Sync  (rx_s)
    );

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            rx_dv     <= 1'b0;
            rx_err    <= 1'b0;
            rx_active <= 1'b0;
        end else begin
            // Strobes are single-cycle by default.
            rx_dv  <= 1'b0;
            rx_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    // Re-check the line at mid start bit to drop glitches.
                    if (cnt == HALF_CNT) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state     <= DATA;
                            rx_active <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt       <= '0;
                        rx_active <= 1'b0;
                        if (rx_s) begin
                            rx_byte <= shreg;
                            rx_dv   <= 1'b1;
                            state   <= CLEANUP;
                        end else begin
                            rx_err <= 1'b1;
                            state  <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLEANUP: state <= IDLE;
                // Held-low line: wait for idle so no phantom frame starts.
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_if.o_Rx_DV        = rx_dv;
    assign rx_if.o_Rx_Byte      = rx_byte;
    assign rx_if.o_Rx_Frame_Err = rx_err;
    assign rx_if.o_Rx_Active    = rx_active;

endmodule
